// File: rtl/display_scan_ctrl.sv
// Two-requester round-robin front end for a shared binary-to-BCD converter,
// driving a 4-digit multiplexed display. Optional macro DISPLAY_SCAN_CTRL_BLANK_EN blanks zero tens digits.
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [4:0] val0,
  input  logic [4:0] val1,
  output logic [1:0] gnt,
  output logic [4:0] conv_in,
  input  logic [3:0] conv_tens,
  input  logic [3:0] conv_ones,
  output logic [3:0] digit_sel,
  output logic [3:0] digit_bcd,
  output logic       busy
);

  localparam logic [15:0] CNT_MAX = 16'(SCAN_DIV - 32'd1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_prio;
  logic [4:0]      r_val;
  logic            r_slot;
  logic [3:0][3:0] r_digit;
  logic [15:0]     r_cnt;
  logic [1:0]      r_idx;
  logic [1:0]      w_gnt;
  logic [4:0]      w_conv_in;
  logic            w_busy;
  logic [3:0]      w_sel;
  logic [3:0]      w_bcd;

  // Control FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Arbitration, next-state and converter drive; r_prio=1 means requester 1 wins a tie
  always_comb begin
    w_next_state = r_state;
    w_gnt        = 2'b00;
    w_conv_in    = 5'd0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n && (req != 2'b00)) begin
          if (req == 2'b11) begin
            w_gnt = r_prio ? 2'b10 : 2'b01;
          end else begin
            w_gnt = req;
          end
          w_next_state = CONV;
        end else begin
          w_next_state = IDLE;
        end
      end
      CONV: begin
        w_conv_in    = r_val;
        w_busy       = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Request capture and round-robin pointer update at the grant edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val  <= 5'd0;
      r_slot <= 1'b0;
      r_prio <= 1'b0;
    end else if (w_gnt != 2'b00) begin
      r_val  <= w_gnt[1] ? val1 : val0;
      r_slot <= w_gnt[1];
      r_prio <= w_gnt[0];
    end
  end

  // Digit registers load the converter result at the closing edge of CONV
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= '0;
    end else if (r_state == CONV) begin
      if (r_slot) begin
        r_digit[3] <= conv_tens;
        r_digit[2] <= conv_ones;
      end else begin
        r_digit[1] <= conv_tens;
        r_digit[0] <= conv_ones;
      end
    end
  end

  // Refresh counter and digit index, free-running regardless of the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
      r_idx <= 2'd0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= 16'd0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Digit select / BCD decode from the stored registers
  always_comb begin
    w_sel = 4'b0001 << r_idx;
    w_bcd = r_digit[r_idx];
`ifdef DISPLAY_SCAN_CTRL_BLANK_EN
    if (r_idx[0] && (r_digit[r_idx] == 4'd0)) begin
      w_sel = 4'b0000;
      w_bcd = 4'hF;
    end else begin
      w_sel = 4'b0001 << r_idx;
      w_bcd = r_digit[r_idx];
    end
`else
    if (r_idx[0]) begin
      w_sel = 4'b0001 << r_idx;
    end else begin
      w_sel = 4'b0001 << r_idx;
    end
`endif
  end

  assign gnt       = w_gnt;
  assign conv_in   = w_conv_in;
  assign busy      = w_busy;
  assign digit_sel = w_sel;
  assign digit_bcd = w_bcd;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: table-driven updates with a
// conversion scoreboard, a display-scan reference model and corner sequences.
module tb_display_scan_ctrl;

  localparam int TB_DIV = 3;
`ifdef DISPLAY_SCAN_CTRL_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [4:0] val0, val1;
  logic [1:0] gnt;
  logic [4:0] conv_in;
  logic [3:0] conv_tens, conv_ones;
  logic [3:0] digit_sel, digit_bcd;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  display_scan_ctrl #(.SCAN_DIV(TB_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .val0(val0), .val1(val1),
    .gnt(gnt), .conv_in(conv_in), .conv_tens(conv_tens), .conv_ones(conv_ones),
    .digit_sel(digit_sel), .digit_bcd(digit_bcd), .busy(busy)
  );

  always #5 clk = ~clk;

  // external converter
  assign conv_tens = 4'(conv_in / 5'd10);
  assign conv_ones = 4'(conv_in % 5'd10);

  typedef struct packed {
    logic [1:0] req;
    logic [4:0] v0;
    logic [4:0] v1;
    logic [1:0] exp_gnt;
  } vec_t;

  typedef struct packed {
    logic       slot;
    logic [4:0] val;
  } exp_t;

  vec_t       tbl [7];
  exp_t       sb [$];
  logic [3:0] m_dig [4];
  int         m_cnt, m_idx;
  bit         chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scan reference model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_idx <= 0;
    end else if (m_cnt == TB_DIV - 1) begin
      m_cnt <= 0;
      m_idx <= (m_idx + 1) % 4;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      int es, eb;
      es = 1 << m_idx;
      eb = int'(m_dig[m_idx]);
      if (BLANK && (m_idx % 2 == 1) && (eb == 0)) begin
        es = 0;
        eb = 15;
      end
      chk("scan_digit_sel", int'(digit_sel), es);
      chk("scan_digit_bcd", int'(digit_bcd), eb);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req = 2'b00;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(posedge clk); #1;
    req = v.req; val0 = v.v0; val1 = v.v1;
    @(negedge clk);
    chk("gnt_idle", int'(gnt), int'(v.exp_gnt));
    chk("busy_idle", int'(busy), 0);
    chk("conv_in_idle", int'(conv_in), 0);
    sb.push_back({v.exp_gnt[1], v.exp_gnt[1] ? v.v1 : v.v0});
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    chk("busy_conv", int'(busy), 1);
    chk("gnt_conv", int'(gnt), 0);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("conv_in_conv", int'(conv_in), int'(e.val));
      @(posedge clk);
      if (e.slot) begin
        m_dig[3] = 4'(e.val / 10); m_dig[2] = 4'(e.val % 10);
      end else begin
        m_dig[1] = 4'(e.val / 10); m_dig[0] = 4'(e.val % 10);
      end
    end
  endtask

  task automatic wait_show(input int idx, input int exp);
    bit found = 1'b0;
    for (int c = 0; c < 4 * TB_DIV + 4 && !found; c++) begin
      @(negedge clk);
      if (int'(digit_sel) == (1 << idx)) found = 1'b1;
    end
    if (found) chk("show_bcd", int'(digit_bcd), exp);
    else chk("show_timeout", 0, 1);
  endtask

  initial begin
    tbl[0] = '{2'b01, 5'd27, 5'd0,  2'b01};
    tbl[1] = '{2'b10, 5'd0,  5'd31, 2'b10};
    tbl[2] = '{2'b11, 5'd8,  5'd12, 2'b01};
    tbl[3] = '{2'b11, 5'd14, 5'd0,  2'b10};
    tbl[4] = '{2'b11, 5'd9,  5'd3,  2'b01};
    tbl[5] = '{2'b10, 5'd1,  5'd20, 2'b10};
    tbl[6] = '{2'b01, 5'd0,  5'd4,  2'b01};

    rst_n = 1'b0; req = 2'b00; val0 = 5'd0; val1 = 5'd0;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    #3;
    chk("rst_digit_sel", int'(digit_sel), 1);
    chk("rst_digit_bcd", int'(digit_bcd), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_conv_in", int'(conv_in), 0);
    do_reset();
    chk_en = 1'b1;

    for (int i = 0; i < 7; i++) apply(tbl[i]);
    repeat (4 * TB_DIV + 2) @(negedge clk);

    // reset asserted mid-scan with a request pending
    repeat (5) @(negedge clk);
    #2 req = 2'b01; val0 = 5'd13; rst_n = 1'b0;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    #1;
    chk("midrst_digit_sel", int'(digit_sel), 1);
    chk("midrst_digit_bcd", int'(digit_bcd), 0);
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_conv_in", int'(conv_in), 0);
    req = 2'b00;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("step_sel_0", int'(digit_sel), 1);
    for (int k = 1; k <= 4 * TB_DIV + 2; k++) begin
      int ix;
      @(negedge clk);
      ix = (k / TB_DIV) % 4;
      chk("step_sel", int'(digit_sel), (BLANK && (ix % 2 == 1)) ? 0 : (1 << ix));
    end

    // tie from reset, requester 1 keeps requesting through CONV
    do_reset();
    @(posedge clk); #1;
    req = 2'b11; val0 = 5'd5; val1 = 5'd19;
    @(negedge clk);
    chk("tie_gnt_first", int'(gnt), 1);
    @(posedge clk); #1;
    req = 2'b10;
    @(negedge clk);
    chk("tie_gnt_blocked", int'(gnt), 0);
    chk("tie_busy", int'(busy), 1);
    chk("tie_conv_in0", int'(conv_in), 5);
    @(posedge clk);
    m_dig[1] = 4'd0; m_dig[0] = 4'd5;
    @(negedge clk);
    chk("tie_gnt_second", int'(gnt), 2);
    chk("tie_busy_idle", int'(busy), 0);
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    chk("tie_conv_in1", int'(conv_in), 19);
    @(posedge clk);
    m_dig[3] = 4'd1; m_dig[2] = 4'd9;
    wait_show(3, 1);
    wait_show(2, 9);
    wait_show(0, 5);

    // reset during CONV discards the conversion
    do_reset();
    @(posedge clk); #1;
    req = 2'b01; val0 = 5'd27;
    @(negedge clk);
    chk("rc_gnt", int'(gnt), 1);
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    chk("rc_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rc_busy_rst", int'(busy), 0);
    chk("rc_conv_in_rst", int'(conv_in), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_show(0, 0);
    repeat (4 * TB_DIV) @(negedge clk);

    // zero tens digit display / blanking
    do_reset();
    apply('{2'b01, 5'd7, 5'd0, 2'b01});
    begin
      bit found = 1'b0;
      for (int c = 0; c < 4 * TB_DIV + 4 && !found; c++) begin
        @(negedge clk);
        if (m_idx == 1) found = 1'b1;
      end
      if (found) begin
        chk("blank_sel", int'(digit_sel), BLANK ? 0 : 2);
        chk("blank_bcd", int'(digit_bcd), BLANK ? 15 : 0);
      end else begin
        chk("blank_timeout", 0, 1);
      end
    end
    wait_show(0, 7);
    repeat (4 * TB_DIV) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
